regfile_sb: RTL and testbench

- Parametrised multi-port general-purpose register file for the core datapath, with a per-register busy scoreboard.
- Provides NR_RPORTS combinational read ports and NR_WPORTS synchronous write ports.
- Register 0 is hard-wired to zero.
- The scoreboard tracks registers with an outstanding writeback, so issue logic can stall on RAW/WAW hazards through a ready handshake.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_sb_if.sv | 27 ++
 rtl/regfile_scoreboard.sv | 39 +++
 rtl/regfile_sb.sv | 59 +++++
 tb/tb_regfile_sb.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register index and packed-bus helpers for regfile_sb
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NR_REGS = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_REG = 0;
  localparam int BUS_W = 512;
  function automatic logic [BUS_W-1:0] unpack(logic [BUS_W-1:0] bus, int p, int w);
    return (bus >> (p * w)) & ~({BUS_W{1'b1}} << w);
  endfunction
  function automatic logic live(int a, int n);
    return a != ZERO_REG && a < n;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write, read and issue/scoreboard signals of regfile_sb
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NR_REGS = DEF_NR_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_RPORTS = 2,
  parameter int NR_WPORTS = 2
);
  logic [NR_WPORTS-1:0] wen;
  logic [NR_WPORTS*ADDR_WIDTH-1:0] waddr;
  logic [NR_WPORTS*WIDTH-1:0] wdata;
  logic [NR_RPORTS*ADDR_WIDTH-1:0] raddr;
  logic [NR_RPORTS*WIDTH-1:0] rdata;
  logic [NR_RPORTS-1:0] rbusy;
  logic issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic issue_ready;
  logic [NR_REGS-1:0] busy_vec;
  modport master (
    output wen, waddr, wdata, raddr, issue_valid, issue_rd,
    input rdata, rbusy, issue_ready, busy_vec
  );
  modport slave (
    input wen, waddr, wdata, raddr, issue_valid, issue_rd,
    output rdata, rbusy, issue_ready, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, issue_ready and rbusy lookup
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NR_REGS = DEF_NR_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_RPORTS = 2,
  parameter int NR_WPORTS = 2
) (
  input logic clk,
  input logic rst,
  input logic [NR_WPORTS-1:0] wen_i,
  input logic [NR_WPORTS*ADDR_WIDTH-1:0] waddr_i,
  input logic [NR_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  input logic issue_valid_i,
  input logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic issue_ready_o,
  output logic [NR_RPORTS-1:0] rbusy_o,
  output logic [NR_REGS-1:0] busy_o
);
  logic [NR_REGS-1:0] busy_q, busy_d;
  function automatic logic bsy(logic [ADDR_WIDTH-1:0] a);
    return int'(a) < NR_REGS && busy_q[a];
  endfunction
  assign busy_o = busy_q;
  assign issue_ready_o = int'(issue_rd_i) == ZERO_REG || !bsy(issue_rd_i);
  for (genvar g = 0; g < NR_RPORTS; g++) begin : g_rbusy
    assign rbusy_o[g] = bsy(ADDR_WIDTH'(unpack(BUS_W'(raddr_i), g, ADDR_WIDTH)));
  end
  // clears first, then a same-cycle claim re-sets the bit for its new owner
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NR_WPORTS; p++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'(unpack(BUS_W'(waddr_i), p, ADDR_WIDTH));
      if (wen_i[p] && live(int'(a), NR_REGS)) busy_d[a] = 1'b0;
    end
    if (issue_valid_i && issue_ready_o && live(int'(issue_rd_i), NR_REGS)) busy_d[issue_rd_i] = 1'b1;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with busy scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_sb import regfile_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NR_REGS = DEF_NR_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_RPORTS = 2,
  parameter int NR_WPORTS = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  logic [WIDTH-1:0] regs_q [NR_REGS];
  logic [WIDTH-1:0] regs_d [NR_REGS];
  logic [WIDTH-1:0] rd_src [NR_REGS];
  // ascending port order lets the highest-index port win on address collisions
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NR_WPORTS; p++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'(unpack(BUS_W'(bus.waddr), p, ADDR_WIDTH));
      if (bus.wen[p] && live(int'(a), NR_REGS)) regs_d[a] = WIDTH'(unpack(BUS_W'(bus.wdata), p, WIDTH));
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NR_REGS; i++) regs_q[i] <= (i == ZERO_REG) ? '0 : rst ? RESET_VAL : regs_d[i];
`ifdef REGFILE_BYPASS_EN
  assign rd_src = regs_d;
`else
  assign rd_src = regs_q;
`endif
  always_comb begin
    bus.rdata = '0;
    for (int r = 0; r < NR_RPORTS; r++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'(unpack(BUS_W'(bus.raddr), r, ADDR_WIDTH));
      bus.rdata[r*WIDTH +: WIDTH] = int'(a) < NR_REGS ? rd_src[a] : '0;
    end
  end
  regfile_scoreboard #(
    .NR_REGS(NR_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NR_RPORTS(NR_RPORTS),
    .NR_WPORTS(NR_WPORTS)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .wen_i(bus.wen),
    .waddr_i(bus.waddr),
    .raddr_i(bus.raddr),
    .issue_valid_i(bus.issue_valid),
    .issue_rd_i(bus.issue_rd),
    .issue_ready_o(bus.issue_ready),
    .rbusy_o(bus.rbusy),
    .busy_o(bus.busy_vec)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against an array-based model
module tb_regfile_sb;
  localparam int W = 32, NR = 32, AW = 5, NRP = 2, NWP = 2;
  localparam logic [31:0] RV = 32'h5A;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  logic [31:0] mreg [NR];
  bit mbusy [NR];
  regfile_sb_if #(.WIDTH(W), .NR_REGS(NR), .ADDR_WIDTH(AW), .NR_RPORTS(NRP), .NR_WPORTS(NWP)) bus();
  regfile_sb #(.WIDTH(W), .NR_REGS(NR), .ADDR_WIDTH(AW), .NR_RPORTS(NRP), .NR_WPORTS(NWP), .RESET_VAL(RV))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cmp(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] e_rd(int a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : mreg[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NWP; p++)
      if (a != 0 && bus.wen[p] && int'(bus.waddr[p*AW +: AW]) == a) v = bus.wdata[p*W +: W];
`endif
    return v;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        mreg[i] = (i == 0) ? 32'h0 : RV;
        mbusy[i] = 0;
      end
      chk_en = 1;
    end else begin
      int rd;
      bit acc;
      rd = int'(bus.issue_rd);
      acc = bus.issue_valid && (rd == 0 || !mbusy[rd]);
      for (int p = 0; p < NWP; p++) begin
        int a;
        a = int'(bus.waddr[p*AW +: AW]);
        if (bus.wen[p] && a != 0) begin
          mreg[a] = bus.wdata[p*W +: W];
          mbusy[a] = 0;
        end
      end
      if (acc && rd != 0) mbusy[rd] = 1;
    end
  end
  always @(negedge clk) if (chk_en) begin
    logic [31:0] bv;
    for (int r = 0; r < NRP; r++) begin
      int a;
      a = int'(bus.raddr[r*AW +: AW]);
      cmp($sformatf("rdata%0d", r), bus.rdata[r*W +: W], e_rd(a));
      cmp($sformatf("rbusy%0d", r), 32'(bus.rbusy[r]), 32'(mbusy[a]));
    end
    bv = 0;
    for (int i = 0; i < NR; i++) bv[i] = mbusy[i];
    cmp("busy_vec", bus.busy_vec, bv);
    cmp("issue_ready", 32'(bus.issue_ready), 32'(bus.issue_rd == 0 || !mbusy[bus.issue_rd]));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW-1:0] pick();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 6));
  endfunction
  initial begin
    bus.wen = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr = 0;
    bus.issue_valid = 1; bus.issue_rd = 2;
    step(); step();
    rst = 0; bus.issue_valid = 0; bus.issue_rd = 3; bus.raddr = {5'd31, 5'd1};
    @(negedge clk);
    cmp("rst_x1", bus.rdata[31:0], 32'h5A);
    cmp("rst_x31", bus.rdata[63:32], 32'h5A);
    cmp("rst_busy", bus.busy_vec, 32'h0);
    cmp("rst_ready", 32'(bus.issue_ready), 32'h1);
    step(); bus.raddr = {5'd0, 5'd0};
    @(negedge clk); cmp("rst_x0", bus.rdata[31:0], 32'h0);
    step(); bus.wen = 2'b11; bus.waddr = {5'd3, 5'd3}; bus.wdata = {32'h22, 32'h11}; bus.raddr = {5'd0, 5'd3};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    cmp("same_cycle_x3", bus.rdata[31:0], 32'h22);
`else
    cmp("same_cycle_x3", bus.rdata[31:0], 32'h5A);
`endif
    step(); bus.wen = 0;
    @(negedge clk); cmp("collide_x3", bus.rdata[31:0], 32'h22);
    step(); bus.wen = 2'b01; bus.waddr = {5'd0, 5'd0}; bus.wdata = {32'h0, 32'hFFFF_FFFF}; bus.raddr = {5'd0, 5'd0};
    step(); bus.wen = 0;
    @(negedge clk);
    cmp("x0_data", bus.rdata[31:0], 32'h0);
    cmp("x0_busy", 32'(bus.busy_vec[0]), 32'h0);
    step(); bus.issue_valid = 1; bus.issue_rd = 5; bus.raddr = {5'd0, 5'd5};
    @(negedge clk); cmp("x5_ready0", 32'(bus.issue_ready), 32'h1);
    step();
    @(negedge clk);
    cmp("x5_ready1", 32'(bus.issue_ready), 32'h0);
    cmp("x5_rbusy", 32'(bus.rbusy[0]), 32'h1);
    step(); bus.wen = 2'b01; bus.waddr = {5'd0, 5'd5}; bus.wdata = {32'h0, 32'h77};
    @(negedge clk);
    cmp("x5_ready_wr", 32'(bus.issue_ready), 32'h0);
    cmp("x5_rbusy_wr", 32'(bus.rbusy[0]), 32'h1);
    step(); bus.wen = 0;
    @(negedge clk);
    cmp("x5_ready2", 32'(bus.issue_ready), 32'h1);
    cmp("x5_data", bus.rdata[31:0], 32'h77);
    cmp("x5_clear", 32'(bus.busy_vec[5]), 32'h0);
    step(); bus.issue_rd = 7; bus.raddr = {5'd0, 5'd7}; bus.wen = 2'b01; bus.waddr = {5'd0, 5'd7}; bus.wdata = {32'h0, 32'hABCD};
    @(negedge clk); cmp("x7_ready", 32'(bus.issue_ready), 32'h1);
    step(); bus.wen = 0; bus.issue_valid = 0;
    @(negedge clk);
    cmp("x7_setwins", 32'(bus.busy_vec[7]), 32'h1);
    cmp("x7_data", bus.rdata[31:0], 32'hABCD);
    cmp("x5_reclaim", 32'(bus.busy_vec[5]), 32'h1);
    step(); bus.issue_valid = 1; bus.issue_rd = 7; bus.wen = 2'b01; bus.waddr = {5'd0, 5'd7}; bus.wdata = {32'h0, 32'hBEEF};
    @(negedge clk); cmp("x7_stall", 32'(bus.issue_ready), 32'h0);
    step(); bus.issue_valid = 0; bus.wen = 0;
    @(negedge clk);
    cmp("x7_cleared", 32'(bus.busy_vec[7]), 32'h0);
    cmp("x7_data2", bus.rdata[31:0], 32'hBEEF);
    step(); bus.issue_valid = 1; bus.issue_rd = 9; bus.wen = 2'b01; bus.waddr = {5'd0, 5'd10}; bus.wdata = {32'h0, 32'h1234};
    step(); bus.issue_valid = 0; bus.wen = 0; bus.raddr = {5'd0, 5'd10};
    @(negedge clk);
    cmp("x9_busy", 32'(bus.busy_vec[9]), 32'h1);
    cmp("x10_data", bus.rdata[31:0], 32'h1234);
    step(); rst = 1; bus.issue_valid = 1; bus.issue_rd = 2;
    step(); rst = 0; bus.issue_valid = 0;
    @(negedge clk);
    cmp("rst2_busy", bus.busy_vec, 32'h0);
    cmp("rst2_x10", bus.rdata[31:0], 32'h5A);
    cmp("rst2_x2_ready", 32'(bus.issue_ready), 32'h1);
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      bus.wen = ($urandom_range(0, 2) == 0) ? NWP'($urandom) : '0;
      bus.issue_valid = 1'($urandom);
      bus.issue_rd = pick();
      for (int p = 0; p < NWP; p++) begin
        bus.waddr[p*AW +: AW] = pick();
        bus.wdata[p*W +: W] = $urandom;
      end
      for (int r = 0; r < NRP; r++) bus.raddr[r*AW +: AW] = pick();
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
